// File: rtl/peak_pkg.sv
// Shared types for the frame peak tracker.
// Sample width and the frame FSM state encoding.
package peak_pkg;

    localparam int DATA_W = 3;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        RESULT
    } peak_state_t;

endpackage

// File: rtl/comparator_3bit.sv
// Unsigned 3-bit magnitude comparator.
// Exactly one of GT, EQ, LT is high.
module comparator_3bit (
    input  logic [2:0] A,
    input  logic [2:0] B,
    output logic       GT,
    output logic       EQ,
    output logic       LT
);

    assign GT = A > B;
    assign EQ = A == B;
    assign LT = A < B;

endmodule

// File: rtl/frame_peak_tracker.sv
// Per-frame max/min tracker over a valid/ready sample stream.
// Reports max, min and the number of samples equal to the max.
module frame_peak_tracker
    import peak_pkg::*;
#(
    parameter int FRAME_LEN = 8,
    parameter int CNT_W     = $clog2(FRAME_LEN + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_max,
    output logic [DATA_W-1:0] out_min,
    output logic [CNT_W-1:0]  out_max_cnt
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    peak_state_t       state_q;
    peak_state_t       state_d;
    logic [DATA_W-1:0] max_q;
    logic [DATA_W-1:0] min_q;
    logic [CNT_W-1:0]  max_cnt_q;
    logic [CNT_W-1:0]  seen_q;

    logic gt_max, eq_max, lt_max;
    logic gt_min, eq_min, lt_min;
    logic unused_cmp;

    logic accept;
    logic out_fire;
    logic frame_done;
    logic first;

    comparator_3bit u_cmp_max (
        .A  (in_data),
        .B  (max_q),
        .GT (gt_max),
        .EQ (eq_max),
        .LT (lt_max)
    );

    comparator_3bit u_cmp_min (
        .A  (in_data),
        .B  (min_q),
        .GT (gt_min),
        .EQ (eq_min),
        .LT (lt_min)
    );

    assign unused_cmp = lt_max ^ gt_min ^ eq_min;

    assign in_ready   = state_q != RESULT;
    assign out_valid  = state_q == RESULT;
    assign accept     = in_valid && in_ready;
    assign out_fire   = out_valid && out_ready;
    assign first      = state_q == IDLE;
    // seen_q is zero in IDLE, so this also covers FRAME_LEN == 1
    assign frame_done = (seen_q + ONE) == LAST;

    assign out_max     = max_q;
    assign out_min     = min_q;
    assign out_max_cnt = max_cnt_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) state_d = frame_done ? RESULT : ACCUM;
            end
            ACCUM: begin
                if (accept && frame_done) state_d = RESULT;
            end
            RESULT: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            max_q     <= '0;
            min_q     <= '0;
            max_cnt_q <= '0;
            seen_q    <= '0;
        end else begin
            state_q <= state_d;
            if (out_fire) begin
                seen_q <= '0;
            end else if (accept) begin
                seen_q <= seen_q + ONE;
                if (first) begin
                    max_q     <= in_data;
                    min_q     <= in_data;
                    max_cnt_q <= ONE;
                end else begin
                    if (gt_max) begin
                        max_q     <= in_data;
                        max_cnt_q <= ONE;
                    end else if (eq_max) begin
                        max_cnt_q <= max_cnt_q + ONE;
                    end
                    if (lt_min) min_q <= in_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_frame_peak_tracker.sv
// Scoreboard bench for frame_peak_tracker (FRAME_LEN 8 and 1 builds).
// Reference model computes frame stats directly from sample lists.
module tb_frame_peak_tracker;

    typedef struct {
        int mx;
        int mn;
        int cnt;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [2:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [2:0] out_max;
    logic [2:0] out_min;
    logic [3:0] out_max_cnt;

    logic       v1;
    logic [2:0] d1;
    logic       in_ready1;
    logic       out_valid1;
    logic       out_ready1;
    logic [2:0] out_max1;
    logic [2:0] out_min1;
    logic [0:0] out_max_cnt1;

    int   n_chk = 0;
    int   n_pass = 0;
    exp_t q8[$];
    exp_t q1[$];
    int   frm[$];
    bit   rnd_ready = 0;
    bit   fixed_ready = 1;
    int   cyc = 0;
    int   acc_cyc = -10;
    bit   pv = 0;
    bit   rel_chk = 0;

    frame_peak_tracker #(.FRAME_LEN(8)) dut8 (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_max     (out_max),
        .out_min     (out_min),
        .out_max_cnt (out_max_cnt)
    );

    frame_peak_tracker #(.FRAME_LEN(1)) dut1 (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (v1),
        .in_data     (d1),
        .in_ready    (in_ready1),
        .out_valid   (out_valid1),
        .out_ready   (out_ready1),
        .out_max     (out_max1),
        .out_min     (out_min1),
        .out_max_cnt (out_max_cnt1)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic exp_t model(input int s[$]);
        exp_t e;
        e.mx = s[0];
        e.mn = s[0];
        foreach (s[i]) begin
            if (s[i] > e.mx) e.mx = s[i];
            if (s[i] < e.mn) e.mn = s[i];
        end
        e.cnt = 0;
        foreach (s[i]) if (s[i] == e.mx) e.cnt++;
        return e;
    endfunction

    // out_ready changes only here, well away from both clock edges
    always @(posedge clk) begin
        #2;
        if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
        else out_ready = fixed_ready;
    end

    always @(posedge clk) begin
        cyc++;
        if (!rst && in_valid && in_ready) acc_cyc = cyc;
    end

    always @(negedge clk) begin
        if (rst) begin
            pv = 0;
            rel_chk = 0;
        end else begin
            if (out_valid && !pv) check("latency", cyc, acc_cyc);
            if (rel_chk) begin
                check("post_ready", int'(in_ready), 1);
                check("post_valid", int'(out_valid), 0);
                rel_chk = 0;
            end
            if (out_valid && out_ready) begin
                if (q8.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else begin
                    exp_t e;
                    e = q8.pop_front();
                    check("max", int'(out_max), e.mx);
                    check("min", int'(out_min), e.mn);
                    check("max_cnt", int'(out_max_cnt), e.cnt);
                end
                check("ready_in_result", int'(in_ready), 0);
                rel_chk = 1;
            end
            pv = out_valid;
        end
    end

    always @(negedge clk) begin
        if (!rst && out_valid1 && out_ready1) begin
            if (q1.size() == 0) begin
                check("f1_unexpected", 1, 0);
            end else begin
                exp_t e;
                e = q1.pop_front();
                check("f1_max", int'(out_max1), e.mx);
                check("f1_min", int'(out_min1), e.mn);
                check("f1_cnt", int'(out_max_cnt1), e.cnt);
            end
        end
    end

    task automatic send_n(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            if ((gap == 1 && i > 0) || (gap == 2 && $urandom_range(0, 2) == 0)) begin
                in_valid = 0;
                @(negedge clk);
            end
            in_valid = 1;
            in_data  = 3'(frm[i]);
            for (int g = 0; g < 100 && !in_ready; g++) @(negedge clk);
            if (!in_ready) check("in_ready_timeout", 0, 1);
            @(negedge clk);
        end
        in_valid = 0;
    endtask

    task automatic run_frame(input int gap);
        q8.push_back(model(frm));
        send_n(8, gap);
    endtask

    task automatic drain();
        for (int g = 0; g < 300 && q8.size() != 0; g++) @(negedge clk);
        check("drain", q8.size(), 0);
    endtask

    initial begin
        int cap_max, cap_min, cap_cnt;
        rst = 1;
        in_valid = 0;
        in_data = 0;
        v1 = 0;
        d1 = 0;
        out_ready1 = 1;
        repeat (2) @(negedge clk);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_max", int'(out_max), 0);
        check("rst_min", int'(out_min), 0);
        check("rst_cnt", int'(out_max_cnt), 0);
        check("rst_f1_valid", int'(out_valid1), 0);
        rst = 0;

        frm = '{3, 5, 5, 1, 7, 7, 2, 0};
        run_frame(0);
        drain();

        frm = '{4, 4, 4, 4, 4, 4, 4, 4};
        run_frame(0);
        drain();

        fixed_ready = 0;
        frm = '{2, 6, 1, 6, 3, 6, 5, 0};
        run_frame(0);
        for (int g = 0; g < 20 && !out_valid; g++) @(negedge clk);
        check("stall_valid_up", int'(out_valid), 1);
        cap_max = out_max;
        cap_min = out_min;
        cap_cnt = out_max_cnt;
        repeat (5) begin
            @(negedge clk);
            check("stall_valid", int'(out_valid), 1);
            check("stall_ready", int'(in_ready), 0);
            check("stall_max", int'(out_max), cap_max);
            check("stall_min", int'(out_min), cap_min);
            check("stall_cnt", int'(out_max_cnt), cap_cnt);
        end
        fixed_ready = 1;
        drain();

        frm = '{0, 1, 2, 3, 4, 5, 6, 7};
        run_frame(1);
        drain();

        frm = '{6, 6, 6, 6};
        send_n(4, 0);
        rst = 1;
        @(negedge clk);
        check("mid_rst_max", int'(out_max), 0);
        check("mid_rst_min", int'(out_min), 0);
        check("mid_rst_cnt", int'(out_max_cnt), 0);
        check("mid_rst_valid", int'(out_valid), 0);
        check("mid_rst_ready", int'(in_ready), 1);
        rst = 0;
        frm = '{1, 1, 1, 1, 1, 1, 1, 1};
        run_frame(0);
        drain();

        rnd_ready = 1;
        repeat (12) begin
            int lo, hi;
            lo = $urandom_range(0, 7);
            hi = $urandom_range(lo, 7);
            frm = {};
            repeat (8) frm.push_back($urandom_range(lo, hi));
            run_frame(2);
        end
        rnd_ready = 0;
        drain();

        for (int k = 0; k < 2; k++) begin
            int val;
            exp_t e;
            val = (k == 0) ? 5 : 2;
            e.mx = val;
            e.mn = val;
            e.cnt = 1;
            q1.push_back(e);
            v1 = 1;
            d1 = 3'(val);
            for (int g = 0; g < 20 && !in_ready1; g++) @(negedge clk);
            check("f1_ready_idle", int'(in_ready1), 1);
            @(negedge clk);
            v1 = 0;
            check("f1_result_now", int'(out_valid1), 1);
            check("f1_ready_low", int'(in_ready1), 0);
        end
        for (int g = 0; g < 20 && q1.size() != 0; g++) @(negedge clk);
        check("f1_drain", q1.size(), 0);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
